// File: rtl/caxi4interconnect_gray_ptr_rx_pkg.sv
// Shared helpers for the CDC FIFO Gray pointer transmitter/receiver pair.
//   ptr_w_of        : pointer width (address width plus a wrap bit)
//   sync_stages_ok  : legal synchroniser depth check
//   bin2gray        : binary to reflected Gray
//   gray2bin        : reflected Gray to binary
// The conversions work on a fixed PTR_MAX_W-bit container. Callers
// zero-extend their pointer into it and truncate the result. Leading
// zeros are neutral for both conversions.
package caxi4interconnect_gray_ptr_rx_pkg;

    localparam int PTR_MAX_W   = 32;
    localparam int SYNC_MIN    = 2;
    localparam int SYNC_MAX    = 4;

    function automatic int ptr_w_of(input int addr_width);
        return addr_width + 1;
    endfunction

    function automatic bit sync_stages_ok(input int n);
        return (n >= SYNC_MIN) && (n <= SYNC_MAX);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
        logic [PTR_MAX_W-1:0] b;
        b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
        for (int i = PTR_MAX_W-2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

endpackage

// File: rtl/caxi4interconnect_gray_ptr_rx_gray2bin.sv
// Combinational Gray to binary decoder.
//   gray : Gray-coded input, n_bits wide
//   bin  : binary equivalent, n_bits wide
module caxi4interconnect_Gray2Bin
    import caxi4interconnect_gray_ptr_rx_pkg::*;
#(
    parameter int n_bits = 5
) (
    input  logic [n_bits-1:0] gray,
    output logic [n_bits-1:0] bin
);

    assign bin = n_bits'(gray2bin(PTR_MAX_W'(gray)));

endmodule

// File: rtl/caxi4interconnect_gray_ptr_rx.sv
// Read-side pointer receiver for a clock-domain-crossing FIFO.
// Synchronises the Gray write pointer into ACLK, decodes it to binary and
// keeps the local read pointer in binary and Gray form.
//   ACLK, sysReset : read clock, synchronous active-high reset
//   grayPtrIn      : Gray write pointer from the write domain
//   rdEn           : pop request
//   rdAddr         : RAM read address (low bits of rdPtrBin)
//   rdPtrBin/Gray  : registered read pointer; Gray copy goes to write side
//   wrPtrBinSync   : synchronised, decoded write pointer
//   empty, fillLevel, popAck : derived from registers and rdEn only
//   underflowErr   : sticky, set on a pop attempt while empty
module caxi4interconnect_gray_ptr_rx
    import caxi4interconnect_gray_ptr_rx_pkg::*;
#(
    parameter  int ADDR_WIDTH  = 4,
    parameter  int SYNC_STAGES = 2,
    localparam int PTR_W       = ptr_w_of(ADDR_WIDTH)
) (
    input  logic                  ACLK,
    input  logic                  sysReset,
    input  logic [PTR_W-1:0]      grayPtrIn,
    input  logic                  rdEn,
    output logic [ADDR_WIDTH-1:0] rdAddr,
    output logic [PTR_W-1:0]      rdPtrBin,
    output logic [PTR_W-1:0]      rdPtrGray,
    output logic [PTR_W-1:0]      wrPtrBinSync,
    output logic                  empty,
    output logic [PTR_W-1:0]      fillLevel,
    output logic                  popAck,
    output logic                  underflowErr
);

    if (!sync_stages_ok(SYNC_STAGES)) begin : g_bad_sync
        $error("caxi4interconnect_gray_ptr_rx: SYNC_STAGES must be 2..4");
    end

    logic [SYNC_STAGES-1:0][PTR_W-1:0] sync_q;
    logic [PTR_W-1:0]                  wr_bin_dec;
    logic [PTR_W-1:0]                  rd_bin_nxt;
    logic [PTR_W-1:0]                  rd_gray_nxt;

    // Plain flop chain: the write side changes one Gray bit at a time, so
    // whatever the first stage captures is either the old or new pointer.
    always_ff @(posedge ACLK) begin
        if (sysReset) sync_q <= '0;
        else          sync_q <= {sync_q[SYNC_STAGES-2:0], grayPtrIn};
    end

    caxi4interconnect_Gray2Bin #(.n_bits(PTR_W)) u_wr_g2b (
        .gray (sync_q[SYNC_STAGES-1]),
        .bin  (wr_bin_dec)
    );

    assign rd_bin_nxt  = rdPtrBin + PTR_W'(1);
    assign rd_gray_nxt = PTR_W'(bin2gray(PTR_MAX_W'(rd_bin_nxt)));

    // Modular subtraction: the wrap bit makes a full FIFO read as 2^ADDR_WIDTH.
    assign empty     = (rdPtrBin == wrPtrBinSync);
    assign fillLevel = wrPtrBinSync - rdPtrBin;
    assign popAck    = rdEn && !empty;
    assign rdAddr    = rdPtrBin[ADDR_WIDTH-1:0];

    always_ff @(posedge ACLK) begin
        if (sysReset) begin
            wrPtrBinSync <= '0;
            rdPtrBin     <= '0;
            rdPtrGray    <= '0;
            underflowErr <= 1'b0;
        end else begin
            wrPtrBinSync <= wr_bin_dec;
            // Binary and Gray copies advance together so the write side
            // never sees a Gray value that disagrees with rdAddr.
            if (popAck) begin
                rdPtrBin  <= rd_bin_nxt;
                rdPtrGray <= rd_gray_nxt;
            end
            if (rdEn && empty)
                underflowErr <= 1'b1;
        end
    end

endmodule

// File: tb/tb_caxi4interconnect_gray_ptr_rx.sv
module tb_caxi4interconnect_gray_ptr_rx;

    localparam int AW = 4;
    localparam int PW = 5;

    logic          ACLK = 1'b0;
    logic          sysReset;
    logic [PW-1:0] grayPtrIn;
    logic          rdEn;
    logic [AW-1:0] rdAddr;
    logic [PW-1:0] rdPtrBin, rdPtrGray, wrPtrBinSync, fillLevel;
    logic          empty, popAck, underflowErr;

    int n_chk = 0;
    int n_err = 0;

    // Hand-written Gray codes for 0..16
    logic [PW-1:0] gtbl [0:16] = '{
        5'b00000, 5'b00001, 5'b00011, 5'b00010, 5'b00110, 5'b00111,
        5'b00101, 5'b00100, 5'b01100, 5'b01101, 5'b01111, 5'b01110,
        5'b01010, 5'b01011, 5'b01001, 5'b01000, 5'b11000 };

    caxi4interconnect_gray_ptr_rx #(.ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
        .ACLK         (ACLK),
        .sysReset     (sysReset),
        .grayPtrIn    (grayPtrIn),
        .rdEn         (rdEn),
        .rdAddr       (rdAddr),
        .rdPtrBin     (rdPtrBin),
        .rdPtrGray    (rdPtrGray),
        .wrPtrBinSync (wrPtrBinSync),
        .empty        (empty),
        .fillLevel    (fillLevel),
        .popAck       (popAck),
        .underflowErr (underflowErr)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic pop_once();
        rdEn = 1'b1;
        tick();
        rdEn = 1'b0;
    endtask

    function automatic logic [PW-1:0] g(input int v);
        logic [PW-1:0] b;
        b = PW'(v);
        return b ^ (b >> 1);
    endfunction

    initial begin
        sysReset  = 1'b1;
        grayPtrIn = 5'b00110;
        rdEn      = 1'b0;
        tick(); tick();
        chk("rst_empty", 32'(empty), 1);
        chk("rst_fill", 32'(fillLevel), 0);
        chk("rst_rdgray", 32'(rdPtrGray), 0);
        chk("rst_uflow", 32'(underflowErr), 0);
        chk("rst_popack", 32'(popAck), 0);
        chk("rst_rdaddr", 32'(rdAddr), 0);

        // Latency: write pointer 0 -> 1
        sysReset  = 1'b0;
        grayPtrIn = 5'b00000;
        tick(); tick(); tick();
        grayPtrIn = 5'b00001;
        tick(); chk("lat_e0_empty", 32'(empty), 1);
        tick(); chk("lat_e1_empty", 32'(empty), 1);
        tick(); chk("lat_e2_empty", 32'(empty), 0);
        chk("lat_e2_fill", 32'(fillLevel), 1);
        rdEn = 1'b1; #1;
        chk("lat_popack", 32'(popAck), 1);
        tick(); rdEn = 1'b0;
        chk("lat_rdbin", 32'(rdPtrBin), 1);
        chk("lat_rdgray", 32'(rdPtrGray), 5'b00001);
        chk("lat_empty", 32'(empty), 1);

        // Full: walk write pointer 0..16 from a clean reset
        sysReset  = 1'b1;
        grayPtrIn = 5'b00000;
        tick(); tick();
        sysReset = 1'b0;
        for (int v = 0; v <= 16; v++) begin
            grayPtrIn = gtbl[v];
            tick();
        end
        tick(); tick();
        chk("full_fill", 32'(fillLevel), 5'b10000);
        chk("full_empty", 32'(empty), 0);
        for (int i = 1; i <= 16; i++) begin
            pop_once();
            chk($sformatf("full_pop%0d_gray", i), 32'(rdPtrGray), 32'(gtbl[i]));
        end
        chk("full_drained", 32'(empty), 1);
        chk("full_rdaddr", 32'(rdAddr), 0);

        // Wrap: bring both pointers to 30, then write goes 31 -> 0 -> 1
        for (int v = 17; v <= 30; v++) begin
            grayPtrIn = g(v);
            tick();
        end
        tick(); tick();
        chk("wrap_fill14", 32'(fillLevel), 14);
        for (int i = 0; i < 14; i++) pop_once();
        chk("wrap_rd30_gray", 32'(rdPtrGray), 5'b10001);
        chk("wrap_rd30_empty", 32'(empty), 1);
        grayPtrIn = 5'b10000; tick();
        grayPtrIn = 5'b00000; tick();
        grayPtrIn = 5'b00001; tick();
        tick(); tick();
        chk("wrap_fill", 32'(fillLevel), 3);
        pop_once(); pop_once(); pop_once();
        chk("wrap_rdbin", 32'(rdPtrBin), 1);
        chk("wrap_empty", 32'(empty), 1);

        // Underflow: pop attempt while empty
        rdEn = 1'b1; #1;
        chk("uf_popack", 32'(popAck), 0);
        tick(); rdEn = 1'b0;
        chk("uf_rdbin", 32'(rdPtrBin), 1);
        chk("uf_rdgray", 32'(rdPtrGray), 5'b00001);
        chk("uf_flag", 32'(underflowErr), 1);
        for (int i = 0; i < 10; i++) tick();
        chk("uf_sticky", 32'(underflowErr), 1);

        // Simultaneous arrival and pop: level 1 stays 1
        grayPtrIn = g(2);
        tick(); tick(); tick();
        chk("sim_fill_pre", 32'(fillLevel), 1);
        grayPtrIn = g(3);
        tick(); tick();
        chk("sim_fill_mid", 32'(fillLevel), 1);
        pop_once();
        chk("sim_fill_post", 32'(fillLevel), 1);
        chk("sim_wrsync", 32'(wrPtrBinSync), 3);
        chk("sim_rdbin", 32'(rdPtrBin), 2);

        // Reset mid-stream at level 5, then recover to level 9
        grayPtrIn = g(7);
        tick(); tick(); tick();
        chk("mid_fill5", 32'(fillLevel), 5);
        sysReset  = 1'b1;
        rdEn      = 1'b1;
        grayPtrIn = 5'b01101;
        tick();
        rdEn = 1'b0;
        chk("mid_rst_fill", 32'(fillLevel), 0);
        chk("mid_rst_rdbin", 32'(rdPtrBin), 0);
        chk("mid_rst_uflow", 32'(underflowErr), 0);
        sysReset = 1'b0;
        tick(); tick();
        chk("mid_rel_e2", 32'(empty), 1);
        tick();
        chk("mid_rel_fill", 32'(fillLevel), 9);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
